// File: rtl/sa_result_drain.sv
// De-skews the diagonally staggered systolic-array result bus into whole rows and
// streams one row per beat over valid/ready; capture never stalls, backpressure only delays drain.
module sa_result_drain #(
    parameter int SIZE  = 16,
    parameter int ACC_W = SIZE + 16,
    parameter int LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SIZE*ACC_W-1:0] result,
    output logic [SIZE*ACC_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  start_err
);

    localparam int KW = $clog2(2 * SIZE);
    localparam int RW = $clog2(SIZE + 1);
    localparam int IW = $clog2(SIZE);
    localparam int WW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DRAIN} state_t;

    state_t          state, state_d;
    logic [WW-1:0]   wcnt, wcnt_d;
    logic [KW-1:0]   kcnt, kcnt_d;
    logic [RW-1:0]   rows_done, rows_done_d;
    logic [RW-1:0]   rd_row, rd_row_d;
    logic            start_err_d;
    logic            cap_en;
    logic            hs;
    logic [ACC_W-1:0] mem [SIZE][SIZE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            kcnt      <= '0;
            rows_done <= '0;
            rd_row    <= '0;
            start_err <= 1'b0;
        end else begin
            state     <= state_d;
            wcnt      <= wcnt_d;
            kcnt      <= kcnt_d;
            rows_done <= rows_done_d;
            rd_row    <= rd_row_d;
            start_err <= start_err_d;
        end
    end

    // rows_done counts rows whose last (highest-column) lane has been captured
    assign out_valid = (rd_row < rows_done);
    assign hs        = out_valid & out_ready;
    assign done      = hs & (rd_row == RW'(SIZE - 1));
    assign busy      = (state != IDLE);

    always_comb begin
        state_d     = state;
        wcnt_d      = wcnt;
        kcnt_d      = kcnt;
        rows_done_d = rows_done;
        rd_row_d    = rd_row;
        start_err_d = 1'b0;
        cap_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    kcnt_d = '0;
                    if (LAT == 1) begin
                        state_d = CAPTURE;
                    end else begin
                        state_d = WAIT;
                        wcnt_d  = WW'(1);
                    end
                end
            end
            WAIT: begin
                start_err_d = start;
                if (wcnt == WW'(LAT - 1)) begin
                    state_d = CAPTURE;
                    kcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt + WW'(1);
                end
            end
            CAPTURE: begin
                start_err_d = start;
                cap_en      = 1'b1;
                if (kcnt >= KW'(SIZE - 1))
                    rows_done_d = RW'(kcnt - KW'(SIZE - 2));
                if (kcnt == KW'(2 * SIZE - 2))
                    state_d = DRAIN;
                else
                    kcnt_d = kcnt + KW'(1);
            end
            DRAIN: begin
                start_err_d = start;
            end
            default: state_d = IDLE;
        endcase
        if (hs) begin
            if (rd_row == RW'(SIZE - 1)) begin
                state_d     = IDLE;
                rd_row_d    = '0;
                rows_done_d = '0;
            end else begin
                rd_row_d = rd_row + RW'(1);
            end
        end
    end

    // Lane c at capture step k belongs to row k-c
    always_ff @(posedge clk) begin
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                if (cap_en && kcnt == KW'(r + c))
                    mem[r][c] <= result[c*ACC_W +: ACC_W];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int c = 0; c < SIZE; c++) begin
            if (out_valid)
                out_data[c*ACC_W +: ACC_W] = mem[rd_row[IW-1:0]][c];
        end
    end

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain: directed tiles, expected rows queued at start,
// monitor pops and compares on every handshake.
module tb_sa_result_drain;

    localparam int SIZE  = 4;
    localparam int ACC_W = 20;
    localparam int LAT   = 2;
    localparam int W     = SIZE * ACC_W;

    typedef struct {
        logic [W-1:0] data;
        int           row;
        int           hs_edge;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         busy;
    logic         done;
    logic         start_err;

    int   cyc      = 0;
    int   edge0    = -1000;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    exp_t exp_q[$];

    logic         hold_pend = 1'b0;
    logic [W-1:0] hold_data;

    sa_result_drain #(.SIZE(SIZE), .ACC_W(ACC_W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .result    (result),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .start_err (start_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] row_val(input int r);
        logic [W-1:0] v;
        v = '0;
        for (int c = 0; c < SIZE; c++)
            v[c*ACC_W +: ACC_W] = ACC_W'(100 * (r + c) + c);
        return v;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Array model: the value for capture step k is presented before edge edge0+LAT+k
    initial result = '0;
    always begin
        @(posedge clk);
        #2;
        begin
            int k;
            k = cyc - edge0 - LAT;
            for (int c = 0; c < SIZE; c++) begin
                if (k >= 0 && k <= 2 * SIZE - 2)
                    result[c*ACC_W +: ACC_W] = ACC_W'(100 * k + c);
                else
                    result[c*ACC_W +: ACC_W] = ACC_W'(32'hABC00 + c);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend)
                chk(out_valid && out_data === hold_data, "hold_stable", out_data, hold_data);
            if (!out_valid)
                chk(out_data === '0, "data_zero_idle", out_data, '0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_row", out_data, '0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk(out_data === e.data, $sformatf("row%0d_data", e.row), out_data, e.data);
                    if (e.hs_edge >= 0)
                        chk(cyc == e.hs_edge, $sformatf("row%0d_edge", e.row),
                            W'(cyc - edge0), W'(e.hs_edge - edge0));
                    chk(done === (e.row == SIZE - 1), $sformatf("row%0d_done", e.row),
                        W'(done), W'(e.row == SIZE - 1));
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            if (done === 1'b1) done_cnt++;
            if (start_err === 1'b1) err_cnt++;
        end
    end

    // hs_base < 0: handshake timing not checked
    task automatic do_start(input int hs_base);
        start = 1'b1;
        edge0 = cyc;
        for (int r = 0; r < SIZE; r++) begin
            exp_t e;
            e.data    = row_val(r);
            e.row     = r;
            e.hs_edge = (hs_base < 0) ? -1 : edge0 + hs_base + r;
            exp_q.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(!busy, "idle_timeout", W'(busy), '0);
    endtask

    task automatic end_test(input string name, input int exp_done, input int exp_err);
        tick();
        chk(exp_q.size() == 0, {name, "_rows_left"}, W'(exp_q.size()), '0);
        chk(done_cnt == exp_done, {name, "_done_cnt"}, W'(done_cnt), W'(exp_done));
        chk(err_cnt == exp_err, {name, "_err_cnt"}, W'(err_cnt), W'(exp_err));
        exp_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk({out_valid, busy, done, start_err} === 4'b0, "reset_flags",
            W'({out_valid, busy, done, start_err}), '0);
        chk(out_data === '0, "reset_data", out_data, '0);
        rst = 1'b0;
        tick();

        // 1: free flow, rows handshaken at edges 6..9 after start
        do_start(6);
        wait_idle(60);
        chk(cyc - edge0 == 10, "busy_fall", W'(cyc - edge0), W'(10));
        end_test("t1", 1, 0);

        // 2: held off for 20 cycles, then four consecutive beats
        out_ready = 1'b0;
        do_start(21);
        repeat (20) tick();
        chk(out_valid === 1'b1, "t2_valid_held", W'(out_valid), W'(1));
        out_ready = 1'b1;
        wait_idle(60);
        end_test("t2", 1, 0);

        // 3: random ready
        void'($urandom(32'd1234));
        do_start(-1);
        for (int i = 0; i < 300 && busy; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        wait_idle(60);
        end_test("t3", 1, 0);

        // 4: second start while busy is rejected
        do_start(6);
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(60);
        end_test("t4", 1, 1);

        // 5: reset mid-capture, then a fresh tile
        do_start(6);
        repeat (3) tick();
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk({out_valid, busy, done, start_err} === 4'b0, "t5_reset_flags",
            W'({out_valid, busy, done, start_err}), '0);
        chk(out_data === '0, "t5_reset_data", out_data, '0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk(busy === 1'b0, "t5_idle_after_reset", W'(busy), '0);
        do_start(6);
        wait_idle(60);
        end_test("t5", 1, 0);

        // 6: back-to-back tiles
        do_start(6);
        wait_idle(60);
        do_start(6);
        wait_idle(60);
        end_test("t6", 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
